// File: rtl/sw_cmd_conditioner.sv
// rtl/sw_cmd_conditioner.sv - switch sync/debounce and one-hot command conditioner for the cleaner FSM
module sw_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] sw_raw,
    output logic [3:0] sw_stable,
    output logic       power_off_o,
    output logic       on_o,
    output logic       cleaning_o,
    output logic       evading_o,
    output logic       cmd_stb,
    output logic       conflict
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] stable_d;
    logic [3:0] rise;
    logic [3:0] eff_rise;
    logic [3:0] winner;
    logic [3:0] cmd;
    logic       multi_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

    // Any cycle where s2 matches the accepted level restarts the count.
    for (genvar i = 0; i < 4; i++) begin : g_debounce
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt          <= '0;
                sw_stable[i] <= 1'b0;
            end else if (s2[i] == sw_stable[i]) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                sw_stable[i] <= s2[i];
                cnt          <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d <= '0;
        end else begin
            stable_d <= sw_stable;
        end
    end

    assign rise       = sw_stable & ~stable_d;
    assign multi_rise = ($countones(rise) >= 2);
    // A held power-off switch masks every other request.
    assign eff_rise   = sw_stable[0] ? (rise & 4'b0001) : rise;

    always_comb begin
        winner = 4'b0000;
        if (eff_rise[0]) begin
            winner = 4'b0001;
        end else if (eff_rise[3]) begin
            winner = 4'b1000;
        end else if (eff_rise[2]) begin
            winner = 4'b0100;
        end else if (eff_rise[1]) begin
            winner = 4'b0010;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd      <= 4'b0001;
            cmd_stb  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            cmd_stb  <= 1'b0;
            conflict <= 1'b0;
            if (ena) begin
                conflict <= multi_rise;
                if ((winner != 4'b0000) && (winner != cmd)) begin
                    cmd     <= winner;
                    cmd_stb <= 1'b1;
                end
            end
        end
    end

    assign power_off_o = cmd[0];
    assign on_o        = cmd[1];
    assign cleaning_o  = cmd[2];
    assign evading_o   = cmd[3];

endmodule

// File: tb/tb_sw_cmd_conditioner.sv
// tb/tb_sw_cmd_conditioner.sv - directed self-checking bench for sw_cmd_conditioner
module tb_sw_cmd_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] sw_raw;
    logic [3:0] sw_stable;
    logic       power_off_o;
    logic       on_o;
    logic       cleaning_o;
    logic       evading_o;
    logic       cmd_stb;
    logic       conflict;
    logic [3:0] cmd;

    int total = 0;
    int bad   = 0;

    sw_cmd_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .sw_raw      (sw_raw),
        .sw_stable   (sw_stable),
        .power_off_o (power_off_o),
        .on_o        (on_o),
        .cleaning_o  (cleaning_o),
        .evading_o   (evading_o),
        .cmd_stb     (cmd_stb),
        .conflict    (conflict)
    );

    assign cmd = {evading_o, cleaning_o, on_o, power_off_o};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        sw_raw = 4'b0000;
        @(negedge clk);
        tick();
        tick();
        check("rst_cmd", 32'(cmd), 32'h1);
        check("rst_stable", 32'(sw_stable), 32'h0);
        check("rst_stb", 32'(cmd_stb), 32'h0);
        check("rst_conflict", 32'(conflict), 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_stb", 32'(cmd_stb), 32'h0);
        end
        check("idle_cmd", 32'(cmd), 32'h1);

        // on switch: stable after 6 edges, command after 7
        sw_raw = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("on_pre_stable", 32'(sw_stable), 32'h0);
        end
        tick();
        check("on_stable6", 32'(sw_stable), 32'h2);
        check("on_cmd6", 32'(cmd), 32'h1);
        tick();
        check("on_cmd7", 32'(cmd), 32'h2);
        check("on_stb7", 32'(cmd_stb), 32'h1);
        check("on_conflict7", 32'(conflict), 32'h0);
        tick();
        check("on_stb8", 32'(cmd_stb), 32'h0);
        check("on_cmd8", 32'(cmd), 32'h2);

        // 3-cycle glitches on cleaning never pass the filter
        for (int g = 0; g < 5; g++) begin
            sw_raw = 4'b0110;
            for (int i = 0; i < 3; i++) begin
                tick();
                check("glitch_hi_stable", 32'(sw_stable), 32'h2);
                check("glitch_hi_stb", 32'(cmd_stb), 32'h0);
            end
            sw_raw = 4'b0010;
            for (int i = 0; i < 3; i++) begin
                tick();
                check("glitch_lo_stable", 32'(sw_stable), 32'h2);
                check("glitch_lo_stb", 32'(cmd_stb), 32'h0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("glitch_tail_stable", 32'(sw_stable), 32'h2);
        end
        check("glitch_cmd", 32'(cmd), 32'h2);

        // cleaning and evading together: evading wins, conflict flagged
        sw_raw = 4'b1110;
        repeat (6) tick();
        check("dual_stable", 32'(sw_stable), 32'he);
        tick();
        check("dual_cmd", 32'(cmd), 32'h8);
        check("dual_stb", 32'(cmd_stb), 32'h1);
        check("dual_conflict", 32'(conflict), 32'h1);
        tick();
        check("dual_stb_after", 32'(cmd_stb), 32'h0);
        check("dual_conflict_after", 32'(conflict), 32'h0);

        // falls are ignored
        sw_raw = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("fall_stb", 32'(cmd_stb), 32'h0);
        end
        check("fall_cmd", 32'(cmd), 32'h8);
        check("fall_stable", 32'(sw_stable), 32'h0);

        sw_raw = 4'b0001;
        repeat (7) tick();
        check("poff_cmd", 32'(cmd), 32'h1);
        check("poff_stb", 32'(cmd_stb), 32'h1);
        tick();

        // on request masked while power_off held
        sw_raw = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("dom_stb", 32'(cmd_stb), 32'h0);
        end
        check("dom_cmd", 32'(cmd), 32'h1);
        check("dom_stable", 32'(sw_stable), 32'h3);

        sw_raw = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rel_stb", 32'(cmd_stb), 32'h0);
        end
        check("rel_cmd", 32'(cmd), 32'h1);
        sw_raw = 4'b0000;
        repeat (8) tick();
        sw_raw = 4'b0010;
        repeat (7) tick();
        check("reraise_cmd", 32'(cmd), 32'h2);
        check("reraise_stb", 32'(cmd_stb), 32'h1);
        tick();

        // rise while disabled is lost
        ena    = 1'b0;
        sw_raw = 4'b1010;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("dis_stb", 32'(cmd_stb), 32'h0);
            check("dis_conflict", 32'(conflict), 32'h0);
        end
        check("dis_stable", 32'(sw_stable), 32'ha);
        check("dis_cmd", 32'(cmd), 32'h2);
        ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reen_stb", 32'(cmd_stb), 32'h0);
        end
        check("reen_cmd", 32'(cmd), 32'h2);

        // async reset in the middle of a debounce count
        sw_raw = 4'b1110;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_cmd", 32'(cmd), 32'h1);
        check("arst_stable", 32'(sw_stable), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick();
        check("post_rst_stable", 32'(sw_stable), 32'he);
        check("post_rst_cmd6", 32'(cmd), 32'h1);
        tick();
        check("post_rst_cmd", 32'(cmd), 32'h8);
        check("post_rst_stb", 32'(cmd_stb), 32'h1);
        check("post_rst_conflict", 32'(conflict), 32'h1);
        tick();
        check("post_rst_stb_after", 32'(cmd_stb), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
